// File: rtl/tpu_pkg.sv
// Shared types for the systolic array edge logic: feeder FSM states and the
// per-row token that travels down the west-edge skew lines.
package tpu_pkg;

  localparam int DEFAULT_DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARM    = 2'd1,
    STREAM = 2'd2,
    DRAIN  = 2'd3
  } feeder_state_t;

  typedef struct packed {
    logic                                 sw;
    logic                                 vld;
    logic signed [DEFAULT_DATA_WIDTH-1:0] data;
  } feed_token_t;

endpackage

// File: rtl/systolic_input_feeder_skew.sv
// Fixed-depth token shift register; one instance per PE row produces the
// diagonal skew (row r uses DEPTH = r+1).
module skew_delay_line
  import tpu_pkg::*;
#(
  parameter int  DEPTH = 1,
  parameter type T     = feed_token_t
) (
  input  logic clk,
  input  logic rst,
  input  T     din,
  output T     dout
);

  T stage_q [DEPTH];
  T stage_d [DEPTH];

  always_comb begin
    stage_d[0] = din;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/systolic_input_feeder.sv
// West-edge feeder: accepts ROWS-wide activation vectors and drives each PE
// row with a diagonally skewed {switch, valid, data} stream.
module systolic_input_feeder
  import tpu_pkg::*;
#(
  parameter int ROWS        = 2,
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int MAX_VECTORS = 64
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic [$clog2(MAX_VECTORS+1)-1:0]   num_vectors,
  input  logic                               s_valid,
  output logic                               s_ready,
  input  logic [ROWS*DATA_WIDTH-1:0]         s_data,
  output logic [ROWS*DATA_WIDTH-1:0]         row_input,
  output logic [ROWS-1:0]                    row_valid,
  output logic [ROWS-1:0]                    row_switch,
  output logic                               busy,
  output logic                               done
);

  localparam int CNT_W   = $clog2(MAX_VECTORS + 1);
  localparam int DRAIN_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef struct packed {
    logic                         sw;
    logic                         vld;
    logic signed [DATA_WIDTH-1:0] data;
  } row_token_t;

  feeder_state_t      state_q, state_d;
  logic [CNT_W-1:0]   num_q, num_d;
  logic [CNT_W-1:0]   vec_cnt_q, vec_cnt_d, vec_cnt_inc;
  logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;
  logic               done_q, done_d;
  logic               xfer, last_xfer, drain_last;
  logic               sw_p0, vld_p0;

  assign vec_cnt_inc = vec_cnt_q + CNT_W'(1);
  assign xfer        = s_valid && s_ready;
  assign last_xfer   = xfer && (vec_cnt_inc == num_q);
  // DRAIN must outlast the deepest skew line so row ROWS-1 empties before done.
  assign drain_last  = (drain_cnt_q == DRAIN_W'(ROWS - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ARM;
      ARM:     state_d = (num_q == '0) ? DRAIN : STREAM;
      STREAM:  if (last_xfer) state_d = DRAIN;
      DRAIN:   if (drain_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_ready = 1'b0;
    busy    = 1'b0;
    sw_p0   = 1'b0;
    case (state_q)
      ARM: begin
        busy  = 1'b1;
        sw_p0 = 1'b1;
      end
      STREAM: begin
        busy    = 1'b1;
        s_ready = (vec_cnt_q < num_q);
      end
      DRAIN:   busy = 1'b1;
      default: ;
    endcase
  end

  assign vld_p0 = xfer;

  always_comb begin
    num_d       = num_q;
    vec_cnt_d   = vec_cnt_q;
    drain_cnt_d = drain_cnt_q;
    done_d      = 1'b0;
    if ((state_q == IDLE) && start) begin
      num_d     = num_vectors;
      vec_cnt_d = '0;
    end
    if (xfer) begin
      vec_cnt_d = vec_cnt_inc;
    end
    if (state_q == DRAIN) begin
      drain_cnt_d = drain_last ? '0 : drain_cnt_q + DRAIN_W'(1);
      done_d      = drain_last;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      num_q       <= '0;
      vec_cnt_q   <= '0;
      drain_cnt_q <= '0;
      done_q      <= 1'b0;
    end else begin
      num_q       <= num_d;
      vec_cnt_q   <= vec_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      done_q      <= done_d;
    end
  end

  assign done = done_q;

  // Stage 0 -> row r: r+1 registers of skew
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    row_token_t tok_p0;
    row_token_t tok_out;

    assign tok_p0.sw   = sw_p0;
    assign tok_p0.vld  = vld_p0;
    assign tok_p0.data = vld_p0 ? $signed(s_data[r*DATA_WIDTH +: DATA_WIDTH]) : '0;

    skew_delay_line #(
      .DEPTH (r + 1),
      .T     (row_token_t)
    ) u_skew (
      .clk  (clk),
      .rst  (rst),
      .din  (tok_p0),
      .dout (tok_out)
    );

    assign row_switch[r]                         = tok_out.sw;
    assign row_valid[r]                          = tok_out.vld;
    assign row_input[r*DATA_WIDTH +: DATA_WIDTH] = tok_out.vld ? tok_out.data : '0;
  end

endmodule

// File: tb/tb_systolic_input_feeder.sv
// Directed bench for systolic_input_feeder (ROWS=2, DATA_WIDTH=16); cycle c_k is
// the cycle after the k-th edge counted from the start-acceptance edge (k=0).
module tb_systolic_input_feeder;

  localparam int ROWS = 2;
  localparam int DW   = 16;
  localparam int MAXV = 64;
  localparam int CW   = $clog2(MAXV + 1);

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               start = 1'b0;
  logic [CW-1:0]      num_vectors = '0;
  logic               s_valid = 1'b0;
  logic               s_ready;
  logic [ROWS*DW-1:0] s_data = '0;
  logic [ROWS*DW-1:0] row_input;
  logic [ROWS-1:0]    row_valid;
  logic [ROWS-1:0]    row_switch;
  logic               busy;
  logic               done;

  int err_cnt = 0;
  int chk_cnt = 0;

  always #5 clk = ~clk;

  systolic_input_feeder #(
    .ROWS        (ROWS),
    .DATA_WIDTH  (DW),
    .MAX_VECTORS (MAXV)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .num_vectors (num_vectors),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .row_input   (row_input),
    .row_valid   (row_valid),
    .row_switch  (row_switch),
    .busy        (busy),
    .done        (done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic [31:0] v, input logic [31:0] r0, input logic [31:0] r1);
    s_valid = v[0];
    s_data  = {r1[15:0], r0[15:0]};
  endtask

  task automatic cyc(input string tag, input logic [31:0] sw, input logic [31:0] vld,
                     input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] dn,
                     input logic [31:0] by, input logic [31:0] rdy);
    chk($sformatf("%s.switch", tag), 32'(row_switch), sw);
    chk($sformatf("%s.valid", tag), 32'(row_valid), vld);
    chk($sformatf("%s.row0", tag), 32'(row_input[15:0]), d0);
    chk($sformatf("%s.row1", tag), 32'(row_input[31:16]), d1);
    chk($sformatf("%s.done", tag), 32'(done), dn);
    chk($sformatf("%s.busy", tag), 32'(busy), by);
    chk($sformatf("%s.ready", tag), 32'(s_ready), rdy);
  endtask

  // Two-vector pass checked through c4; poke re-pulses start in STREAM and DRAIN.
  task automatic basic_upto_c4(input string tag, input bit poke);
    start = 1'b1; num_vectors = 7'd2; drv(0, 0, 0);
    step();
    start = 1'b0;
    cyc({tag, ".c0"}, 0, 0, 0, 0, 0, 1, 0);
    drv(1, 'h0100, 'h0200);
    step();
    cyc({tag, ".c1"}, 'b01, 0, 0, 0, 0, 1, 1);
    step();
    cyc({tag, ".c2"}, 'b10, 'b01, 'h0100, 0, 0, 1, 1);
    drv(1, 'h0300, 'h0400); start = poke;
    step();
    cyc({tag, ".c3"}, 0, 'b11, 'h0300, 'h0200, 0, 1, 0);
    drv(0, 0, 0); start = poke;
    step();
    cyc({tag, ".c4"}, 0, 'b10, 0, 'h0400, 0, 1, 0);
    start = 1'b0;
  endtask

  initial begin
    // Reset held with junk on the inputs
    drv(1, 'hAAAA, 'h5555);
    for (int i = 0; i < 3; i++) begin
      step();
      cyc($sformatf("reset%0d", i), 0, 0, 0, 0, 0, 0, 0);
    end
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      cyc($sformatf("idle%0d", i), 0, 0, 0, 0, 0, 0, 0);
    end

    basic_upto_c4("basic", 1'b0);
    step();
    cyc("basic.c5", 0, 0, 0, 0, 1, 0, 0);
    step();
    cyc("basic.c6", 0, 0, 0, 0, 0, 0, 0);

    // Bubble between the two vectors; junk data during the bubble must not leak
    start = 1'b1; num_vectors = 7'd2; drv(0, 0, 0);
    step();
    start = 1'b0;
    cyc("bub.c0", 0, 0, 0, 0, 0, 1, 0);
    drv(1, 'h0100, 'h0200);
    step();
    cyc("bub.c1", 'b01, 0, 0, 0, 0, 1, 1);
    step();
    cyc("bub.c2", 'b10, 'b01, 'h0100, 0, 0, 1, 1);
    drv(0, 'hDEAD, 'hBEEF);
    step();
    cyc("bub.c3", 0, 'b10, 0, 'h0200, 0, 1, 1);
    drv(1, 'h0300, 'h0400);
    step();
    cyc("bub.c4", 0, 'b01, 'h0300, 0, 0, 1, 0);
    drv(0, 0, 0);
    step();
    cyc("bub.c5", 0, 'b10, 0, 'h0400, 0, 1, 0);
    step();
    cyc("bub.c6", 0, 0, 0, 0, 1, 0, 0);
    step();
    cyc("bub.c7", 0, 0, 0, 0, 0, 0, 0);

    // Empty pass: switches only
    start = 1'b1; num_vectors = 7'd0; drv(1, 'h1111, 'h2222);
    step();
    start = 1'b0;
    cyc("zero.c0", 0, 0, 0, 0, 0, 1, 0);
    step();
    cyc("zero.c1", 'b01, 0, 0, 0, 0, 1, 0);
    step();
    cyc("zero.c2", 'b10, 0, 0, 0, 0, 1, 0);
    step();
    cyc("zero.c3", 0, 0, 0, 0, 1, 0, 0);
    drv(0, 0, 0);
    step();
    cyc("zero.c4", 0, 0, 0, 0, 0, 0, 0);

    // Negative values pass through unchanged
    start = 1'b1; num_vectors = 7'd1;
    step();
    start = 1'b0;
    cyc("neg.c0", 0, 0, 0, 0, 0, 1, 0);
    drv(1, 'hFFFF, 'h8000);
    step();
    cyc("neg.c1", 'b01, 0, 0, 0, 0, 1, 1);
    step();
    cyc("neg.c2", 'b10, 'b01, 'hFFFF, 0, 0, 1, 0);
    drv(0, 0, 0);
    step();
    cyc("neg.c3", 0, 'b10, 0, 'h8000, 0, 1, 0);
    step();
    cyc("neg.c4", 0, 0, 0, 0, 1, 0, 0);
    step();

    // Start ignored mid-pass, then accepted the cycle after done
    basic_upto_c4("ign", 1'b1);
    step();
    cyc("ign.c5", 0, 0, 0, 0, 1, 0, 0);
    step();
    cyc("ign.c6", 0, 0, 0, 0, 0, 0, 0);
    start = 1'b1; num_vectors = 7'd1; drv(1, 'h1234, 'h5678);
    step();
    start = 1'b0;
    cyc("b2b.c0", 0, 0, 0, 0, 0, 1, 0);
    step();
    cyc("b2b.c1", 'b01, 0, 0, 0, 0, 1, 1);
    step();
    cyc("b2b.c2", 'b10, 'b01, 'h1234, 0, 0, 1, 0);
    drv(0, 0, 0);
    step();
    cyc("b2b.c3", 0, 'b10, 0, 'h5678, 0, 1, 0);
    step();
    cyc("b2b.c4", 0, 0, 0, 0, 1, 0, 0);
    step();

    // Asynchronous reset while row1 is still draining
    basic_upto_c4("mid", 1'b0);
    #2 rst = 1'b0;
    #1;
    cyc("mid.async", 0, 0, 0, 0, 0, 0, 0);
    step();
    cyc("mid.c5", 0, 0, 0, 0, 0, 0, 0);
    step();
    cyc("mid.c6", 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    step();
    basic_upto_c4("post", 1'b0);
    step();
    cyc("post.c5", 0, 0, 0, 0, 1, 0, 0);
    step();
    cyc("post.c6", 0, 0, 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
